seq_overlap_trimmer: RTL
========================

Name: seq_overlap_trimmer

Overview:
- Sits directly downstream of a job PE's output seq port, between the job PE and the seq encoder.
- A seq carrying eoj=1 may report overlap_len: bytes its match already covered past the job end.
- This block removes those bytes from the head of the following job's seqs so the seq stream covers each input byte exactly once.
- Single registered output stage; latency 1 cycle.

Parameters:
LL_W, 8, literal-length width (matches SEQ_LL_BITS)
ML_W, 8, match-length width; also overlap_len and carry width (matches SEQ_ML_BITS)
OFF_W, 16, offset width (matches SEQ_OFFSET_BITS)
MIN_MATCH, 3, smallest match length allowed on the output

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_seq_valid  in  1  input seq valid
i_seq_ll  in  LL_W  literal length
i_seq_ml  in  ML_W  match length
i_seq_offset  in  OFF_W  offset
i_seq_eoj  in  1  last seq of job
i_seq_overlap_len  in  ML_W  bytes covered past job end; meaningful only when eoj=1
i_seq_delim  in  1  last seq of block
i_seq_ready  out  1  input ready
o_seq_valid  out  1  output valid
o_seq_ll  out  LL_W  trimmed literal length
o_seq_ml  out  ML_W  trimmed match length
o_seq_offset  out  OFF_W  offset
o_seq_eoj  out  1  eoj passthrough
o_seq_delim  out  1  delim passthrough
o_seq_ready  in  1  output ready
o_drop_cnt  out  16  count of fully absorbed seqs, wraps

Behaviour:
- Reset (clk edge with rst_n=0): o_seq_valid=0, all o_seq payload=0, carry_reg=0, pend_reg=0, o_drop_cnt=0. Reset mid-transfer discards the held output.
- i_seq_ready = !o_seq_valid || o_seq_ready. An accept is i_seq_valid && i_seq_ready.
- Output register loads on accept when the seq is emitted. It clears valid on o_seq_ready when there is no emitting accept in the same cycle.
- Full throughput: 1 seq/cycle under continuous o_seq_ready.
- Payload stays stable while o_seq_valid && !o_seq_ready.
- On each accept, with C=carry_reg, P=pend_reg, T=ll+ml (ML_W+1 bits):
  - C==0: emit ll=ll+P, ml, offset. P'=0, C'=0.
  - 0<C<=ll: emit ll=ll-C+P, ml, offset. C'=0, P'=0.
  - ll<C<T: R=T-C.
    - R>=MIN_MATCH: emit ll=P, ml=R, offset. P'=0.
    - Else: no emit, P'=P+R.
    - Either way C'=0.
  - C>=T: no emit. C'=C-T, P'=P.
- After the cases above, if eoj=1: C'=C'+overlap_len.
- Any non-emitted accept increments o_drop_cnt.
- delim=1 seq is always emitted:
  - If the rules above would drop it, emit ll=P'(incl. short residual), ml=0, offset=0.
  - Then force C'=0, P'=0. Carry never crosses a block.
- Emitted o_seq_eoj/o_seq_delim equal the input flags. eoj of a dropped non-delim seq is not propagated.
- Width rules:
  - Upstream guarantees ll+P < 2^LL_W; the bench asserts it.
  - C'+overlap_len < 2^ML_W; overflow is an assertion failure.
  - No saturation logic.
- Emitted seq with ml=0 and eoj=0 never occurs except when P' is flushed by delim.

Test Plan:
- No overlap: (ll=5,ml=10,off=100,eoj=0) -> next cycle o_seq (5,10,100), latency 1.
- Trim literals: eoj seq with overlap_len=3, then (ll=7,ml=6) -> second output (4,6).
- Trim into match: overlap_len=9, then (ll=4,ml=12,off=50) -> output (0,7,50), carry 0.
- Short residual: overlap_len=10, then (ll=4,ml=8) -> R=2, dropped, o_drop_cnt=1. Next (ll=3,ml=5) -> output (5,5).
- Multi-seq absorb: overlap_len=20, then (2,5), (3,4), (1,9) -> first two dropped. Third emits (0,4). Then eoj+delim seq fully covered -> (P,0,0,eoj=1,delim=1) and carry cleared.
- Backpressure/reset:
  - o_seq_ready=0 for 4 cycles -> i_seq_ready=0, payload stable.
  - Assert rst_n=0 while o_seq_valid=1 with carry 6 -> next cycle o_seq_valid=0.
  - After reset, (ll=2,ml=4) passes unmodified.

Source files
------------

// File: rtl/seq_overlap_trimmer.sv
// Trims bytes already covered by the previous job's overlapping match from the head of
// the next job's seqs, so each input byte is covered exactly once. One registered output stage.
module seq_overlap_trimmer #(
    parameter int LL_W      = 8,
    parameter int ML_W      = 8,
    parameter int OFF_W     = 16,
    parameter int MIN_MATCH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_seq_valid,
    input  logic [LL_W-1:0]  i_seq_ll,
    input  logic [ML_W-1:0]  i_seq_ml,
    input  logic [OFF_W-1:0] i_seq_offset,
    input  logic             i_seq_eoj,
    input  logic [ML_W-1:0]  i_seq_overlap_len,
    input  logic             i_seq_delim,
    output logic             i_seq_ready,
    output logic             o_seq_valid,
    output logic [LL_W-1:0]  o_seq_ll,
    output logic [ML_W-1:0]  o_seq_ml,
    output logic [OFF_W-1:0] o_seq_offset,
    output logic             o_seq_eoj,
    output logic             o_seq_delim,
    input  logic             o_seq_ready,
    output logic [15:0]      o_drop_cnt
);
    localparam int TW = ((LL_W > ML_W) ? LL_W : ML_W) + 1;

    logic             valid_q;
    logic [LL_W-1:0]  ll_q;
    logic [ML_W-1:0]  ml_q;
    logic [OFF_W-1:0] off_q;
    logic             eoj_q, delim_q;
    logic [ML_W-1:0]  carry_q, carry_d;
    logic [LL_W-1:0]  pend_q, pend_d;
    logic [15:0]      drop_q;

    logic             accept, emit;
    logic [LL_W-1:0]  e_ll;
    logic [ML_W-1:0]  e_ml;
    logic [OFF_W-1:0] e_off;
    logic [TW-1:0]    tot, c_ext, ll_ext, resid;

    assign i_seq_ready = !valid_q || o_seq_ready;
    assign accept      = i_seq_valid && i_seq_ready;

    always_comb begin
        tot     = TW'(i_seq_ll) + TW'(i_seq_ml);
        c_ext   = TW'(carry_q);
        ll_ext  = TW'(i_seq_ll);
        resid   = tot - c_ext;
        emit    = 1'b0;
        e_ll    = '0;
        e_ml    = i_seq_ml;
        e_off   = i_seq_offset;
        carry_d = carry_q;
        pend_d  = pend_q;
        if (carry_q == '0) begin
            emit    = 1'b1;
            e_ll    = i_seq_ll + pend_q;
            pend_d  = '0;
        end else if (c_ext <= ll_ext) begin
            emit    = 1'b1;
            e_ll    = i_seq_ll - LL_W'(carry_q) + pend_q;
            carry_d = '0;
            pend_d  = '0;
        end else if (c_ext < tot) begin
            // Overlap ends inside the match; a residual too short to encode becomes literals
            carry_d = '0;
            if (resid >= TW'(MIN_MATCH)) begin
                emit   = 1'b1;
                e_ll   = pend_q;
                e_ml   = ML_W'(resid);
                pend_d = '0;
            end else begin
                pend_d = pend_q + LL_W'(resid);
            end
        end else begin
            carry_d = ML_W'(c_ext - tot);
        end
        if (i_seq_eoj)
            carry_d = carry_d + i_seq_overlap_len;
        // Block boundary: flush pending literals and never let carry cross it
        if (i_seq_delim) begin
            if (!emit) begin
                emit  = 1'b1;
                e_ll  = pend_d;
                e_ml  = '0;
                e_off = '0;
            end
            carry_d = '0;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ll_q    <= '0;
            ml_q    <= '0;
            off_q   <= '0;
            eoj_q   <= 1'b0;
            delim_q <= 1'b0;
            carry_q <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
        end else begin
            if (accept) begin
                carry_q <= carry_d;
                pend_q  <= pend_d;
            end
            if (accept && emit) begin
                valid_q <= 1'b1;
                ll_q    <= e_ll;
                ml_q    <= e_ml;
                off_q   <= e_off;
                eoj_q   <= i_seq_eoj;
                delim_q <= i_seq_delim;
            end else if (o_seq_ready) begin
                valid_q <= 1'b0;
            end
            if (accept && !emit)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign o_seq_valid  = valid_q;
    assign o_seq_ll     = ll_q;
    assign o_seq_ml     = ml_q;
    assign o_seq_offset = off_q;
    assign o_seq_eoj    = eoj_q;
    assign o_seq_delim  = delim_q;
    assign o_drop_cnt   = drop_q;

endmodule
